// File: rtl/tow_scorer_match.sv
// Tug-of-war match scorer: tracks rope position, per-player game wins and match end.
// Position decodes to a one-hot/bar display; a game win freezes play until new_game.
module tow_scorer_match #(
   parameter int unsigned STEPS       = 3,
   parameter int unsigned FAVOR_LOSER = 1,
   parameter int unsigned MATCH_WINS  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 winrnd,
   input  logic                 right,
   input  logic                 leds_on,
   input  logic                 tie,
   input  logic                 new_game,
   output logic [2*STEPS:0]     score,
   output logic                 game_over,
   output logic [2:0]           left_games,
   output logic [2:0]           right_games,
   output logic                 match_over,
   output logic                 false_start
);

   localparam int unsigned SW  = 2 * STEPS + 1;
   localparam int unsigned PW  = 5;
   localparam int unsigned CW  = 3;
   localparam int          WIN = int'(STEPS) + 1;
   localparam int          EDGE_POS = int'(STEPS);

   logic signed [PW-1:0] p;
   logic signed [PW-1:0] p_nxt;
   logic [CW-1:0]        left_nxt;
   logic [CW-1:0]        right_nxt;
   logic                 fs_nxt;

   int   pi;
   int   dir;
   int   np;
   logic bad;
   logic scored;
   logic restart;
   logic mr;
   logic toward;
   logic big;

   assign pi = int'(p);

   // Status decode from registered state
   assign bad        = (pi > WIN) || (pi < -WIN);
   assign game_over  = (pi == WIN) || (pi == -WIN);
   assign match_over = (left_games == CW'(MATCH_WINS)) || (right_games == CW'(MATCH_WINS));
   assign scored     = winrnd & ~tie & ~game_over & ~match_over;
   assign restart    = new_game & game_over & ~match_over;
   assign mr         = (right & leds_on) | (~right & ~leds_on);

   // Candidate position for a scored push, with loser recovery jump
   always_comb begin
      dir    = mr ? 1 : -1;
      toward = (pi < 0 && mr) || (pi > 0 && !mr);
      big    = (FAVOR_LOSER == 1) && leds_on && toward &&
               ((pi == EDGE_POS) || (pi == -EDGE_POS));
      np     = big ? pi + 2 * dir : pi + dir;
      if (big && ((pi < 0 && np > 0) || (pi > 0 && np < 0)))
         np = 0;
   end

   // Next-state selection; restart outranks a coincident push
   always_comb begin
      p_nxt     = p;
      left_nxt  = left_games;
      right_nxt = right_games;
      fs_nxt    = false_start;
      if (bad) begin
         p_nxt = '0;
      end else if (restart) begin
         p_nxt = '0;
      end else if (scored) begin
         p_nxt  = $signed(PW'(np));
         fs_nxt = ~leds_on;
         if (np == -WIN && left_games < CW'(MATCH_WINS))
            left_nxt = left_games + CW'(1);
         if (np == WIN && right_games < CW'(MATCH_WINS))
            right_nxt = right_games + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p           <= '0;
         left_games  <= '0;
         right_games <= '0;
         false_start <= 1'b0;
      end else begin
         p           <= p_nxt;
         left_games  <= left_nxt;
         right_games <= right_nxt;
         false_start <= fs_nxt;
      end
   end

   // Display: single light per position, bar of lights at a win
   always_comb begin
      score = '0;
      for (int i = 0; i < int'(SW); i++) begin
         if (bad)
            score[i] = ((i % 2) == 0);
         else if (pi == -WIN)
            score[i] = (i > EDGE_POS);
         else if (pi == WIN)
            score[i] = (i < EDGE_POS);
         else
            score[i] = (i == EDGE_POS - pi);
      end
   end

endmodule

// File: tb/tb_tow_scorer_match.sv
// Bench for tow_scorer_match: directed scenarios plus random pushes against a position model.
module tb_tow_scorer_match;

   localparam int STEPS = 3;
   localparam int FAVOR = 1;
   localparam int MW    = 2;
   localparam int WIN   = STEPS + 1;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                winrnd = 1'b0;
   logic                right = 1'b0;
   logic                leds_on = 1'b0;
   logic                tie = 1'b0;
   logic                new_game = 1'b0;
   logic [2*STEPS:0]    score;
   logic                game_over;
   logic [2:0]          left_games;
   logic [2:0]          right_games;
   logic                match_over;
   logic                false_start;

   int errors = 0;
   int checks = 0;

   int mp  = 0;
   int ml  = 0;
   int mrg = 0;
   int mfs = 0;

   tow_scorer_match #(.STEPS(STEPS), .FAVOR_LOSER(FAVOR), .MATCH_WINS(MW)) dut (
      .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .leds_on(leds_on),
      .tie(tie), .new_game(new_game), .score(score), .game_over(game_over),
      .left_games(left_games), .right_games(right_games), .match_over(match_over),
      .false_start(false_start)
   );

   always #5 clk = ~clk;

   function automatic int abs_i(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int exp_score(input int pos);
      if (pos == -WIN) return ((1 << STEPS) - 1) << (STEPS + 1);
      if (pos == WIN)  return (1 << STEPS) - 1;
      return 1 << (STEPS - pos);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".score"}, 32'(score), 32'(exp_score(mp)));
      chk({tag, ".game_over"}, 32'(game_over), 32'(abs_i(mp) == WIN));
      chk({tag, ".left_games"}, 32'(left_games), 32'(ml));
      chk({tag, ".right_games"}, 32'(right_games), 32'(mrg));
      chk({tag, ".match_over"}, 32'(match_over), 32'(ml == MW || mrg == MW));
      chk({tag, ".false_start"}, 32'(false_start), 32'(mfs));
   endtask

   // Reference behaviour for one clock edge given the applied inputs
   task automatic model_step(input logic w, input logic r, input logic l, input logic t, input logic ng);
      bit go, mo;
      int dir, np;
      go = (abs_i(mp) == WIN);
      mo = (ml == MW) || (mrg == MW);
      if (ng && go && !mo) begin
         mp = 0;
      end else if (w && !t && !go && !mo) begin
         dir = (r == l) ? 1 : -1;
         if (FAVOR == 1 && l && abs_i(mp) == STEPS && mp * dir < 0) begin
            np = mp + 2 * dir;
            if (np * mp < 0) np = 0;
         end else begin
            np = mp + dir;
         end
         mp = np;
         if (mp == -WIN && ml < MW) ml++;
         if (mp == WIN && mrg < MW) mrg++;
         mfs = l ? 0 : 1;
      end
   endtask

   task automatic cyc(input logic w, input logic r, input logic l, input logic t, input logic ng,
                      input string tag);
      @(negedge clk);
      winrnd = w; right = r; leds_on = l; tie = t; new_game = ng;
      model_step(w, r, l, t, ng);
      @(posedge clk);
      #1;
      winrnd = 1'b0; new_game = 1'b0;
      check_all(tag);
   endtask

   // Reset asserted between edges; outputs must clear before any clock
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      mp = 0; ml = 0; mrg = 0; mfs = 0;
      check_all(tag);
      chk({tag, ".centre"}, 32'(score), 32'h08);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push_left(input string tag);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, tag);
   endtask

   task automatic push_right(input string tag);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, tag);
   endtask

   initial begin
      int mo_cycles;
      logic w, r, l, t, ng;

      do_reset("init");
      chk("init.go_const", 32'(game_over), 32'd0);
      chk("init.mo_const", 32'(match_over), 32'd0);

      push_right("first_push");
      chk("first_push.const", 32'(score), 32'b0000100);
      chk("first_push.fs_const", 32'(false_start), 32'd0);

      do_reset("rst_mid");
      push_left("l1");  chk("l1.const", 32'(score), 32'b0010000);
      push_left("l2");  chk("l2.const", 32'(score), 32'b0100000);
      push_left("l3");  chk("l3.const", 32'(score), 32'b1000000);
      push_left("l4");  chk("l4.const", 32'(score), 32'b1110000);
      chk("l4.go_const", 32'(game_over), 32'd1);
      chk("l4.left_const", 32'(left_games), 32'd1);

      push_right("frozen");
      chk("frozen.const", 32'(score), 32'b1110000);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "restart");
      chk("restart.const", 32'(score), 32'b0001000);
      chk("restart.left_const", 32'(left_games), 32'd1);

      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "tie_centre");
      push_left("a1"); push_left("a2"); push_left("a3");
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "tie_edge");
      chk("tie_edge.const", 32'(score), 32'b1000000);
      push_right("recover");
      chk("recover.const", 32'(score), 32'b0010000);
      push_left("b1"); push_left("b2"); push_left("b3");
      chk("match.const", 32'(match_over), 32'd1);
      chk("match.left_const", 32'(left_games), 32'd2);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ng_after_match");
      chk("ng_after_match.const", 32'(score), 32'b1110000);

      do_reset("rst_match");
      push_left("c1"); push_left("c2"); push_left("c3");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "jump_light");
      chk("jump_light.const", 32'(score), 32'b0100000);
      chk("jump_light.fs_const", 32'(false_start), 32'd1);
      push_left("d1"); push_left("d2");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "ng_and_push");
      chk("ng_and_push.const", 32'(score), 32'b0001000);
      chk("ng_and_push.left_const", 32'(left_games), 32'd1);
      chk("ng_and_push.right_const", 32'(right_games), 32'd0);

      push_right("e1"); push_right("e2"); push_right("e3");
      push_left("right_recover");
      chk("right_recover.const", 32'(score), 32'b0000100);
      push_right("e4"); push_right("e5"); push_right("e6");
      chk("right_win.const", 32'(score), 32'b0000111);
      chk("right_win.right_const", 32'(right_games), 32'd1);

      do_reset("rst_pre_random");
      mo_cycles = 0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0 || mo_cycles > 6) begin
            do_reset("rand_rst");
            mo_cycles = 0;
         end else begin
            w  = ($urandom_range(0, 3) != 0);
            r  = 1'($urandom_range(0, 1));
            l  = ($urandom_range(0, 4) != 0);
            t  = ($urandom_range(0, 9) == 0);
            ng = ($urandom_range(0, 5) == 0);
            cyc(w, r, l, t, ng, "rand");
            if (ml == MW || mrg == MW) mo_cycles++;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
